avalon_timer_bank: RTL

Parametrised Avalon-MM slave that exposes CHANNELS independent down-counter timers behind one word-addressed register window.
It is the generalised successor of the two-counter Avalon core and adds:
- per-channel reload, control and sticky status registers
- a registered read-data path
- a maskable, level-sensitive interrupt

It sits on the system Avalon bus as a peripheral; irq goes to the interrupt controller.

---
 rtl/avalon_timer_bank_pkg.sv | 31 +++
 rtl/avalon_timer_bank_if.sv | 22 ++
 rtl/avalon_timer_bank_channel.sv | 72 +++++++
 rtl/avalon_timer_bank.sv | 82 ++++++++
 4 files changed

// File: rtl/avalon_timer_bank_pkg.sv
// rtl/avalon_timer_bank_pkg.sv - register map, bit indices and CTRL layout for the timer bank
package avalon_timer_pkg;

    localparam logic [1:0] REG_COUNT  = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    localparam int STAT_TC  = 0;
    localparam int STAT_OVF = 1;

    typedef struct packed {
        logic ie;
        logic autoreload;
        logic en;
    } ctrl_t;

    // Unpack a bus write word into the CTRL fields; unused bits are dropped.
    function automatic ctrl_t to_ctrl(input logic [31:0] d);
        ctrl_t c;
        c.en         = d[CTRL_EN];
        c.autoreload = d[CTRL_AUTO];
        c.ie         = d[CTRL_IE];
        return c;
    endfunction

endpackage

// File: rtl/avalon_timer_bank_if.sv
// rtl/avalon_timer_bank_if.sv - Avalon-MM slave bus bundle for the timer bank
interface avalon_timer_bank_if #(
    parameter int ADDR_W = 4
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       dataIn;
    logic              readValid;
    logic [31:0]       dataOut;
    logic              irq;

    modport master (
        output read, write, address, dataIn,
        input  readValid, dataOut, irq
    );

    modport slave (
        input  read, write, address, dataIn,
        output readValid, dataOut, irq
    );
endinterface

// File: rtl/avalon_timer_bank_channel.sv
// rtl/avalon_timer_bank_channel.sv - one down-counter timer with reload, control and sticky status
module timer_channel
    import avalon_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             we_count,
    input  logic             we_reload,
    input  logic             we_ctrl,
    input  logic [1:0]       w1c,
    input  logic [31:0]      dataIn,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] reload,
    output ctrl_t            ctrl,
    output logic [1:0]       status,
    output logic             irqReq
);

    // A software COUNT write wins over the hardware terminal event in the same cycle.
    logic tc_event;
    assign tc_event = ctrl.en && (count == '0) && !we_count;

    // Counter: software write, else decrement, else reload at zero in auto mode.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (we_count) begin
            count <= dataIn[WIDTH-1:0];
        end else if (ctrl.en) begin
            if (count != '0) begin
                count <= count - WIDTH'(1);
            end else if (ctrl.autoreload) begin
                count <= reload;
            end
        end
    end

    // Reload value is purely software owned.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            reload <= '0;
        end else if (we_reload) begin
            reload <= dataIn[WIDTH-1:0];
        end
    end

    // Control: software write applies next cycle; a one-shot terminal event drops EN.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ctrl <= '0;
        end else if (we_ctrl) begin
            ctrl <= to_ctrl(dataIn);
        end else if (tc_event && !ctrl.autoreload) begin
            ctrl.en <= 1'b0;
        end
    end

    // Sticky status with W1C; a hardware set beats a clear on the same bit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            status <= 2'b00;
        end else begin
            status[STAT_TC]  <= (status[STAT_TC] & ~w1c[STAT_TC]) | tc_event;
            status[STAT_OVF] <= (status[STAT_OVF] & ~w1c[STAT_OVF]) | (tc_event & status[STAT_TC]);
        end
    end

    assign irqReq = status[STAT_TC] & ctrl.ie;

endmodule

// File: rtl/avalon_timer_bank.sv
// rtl/avalon_timer_bank.sv - Avalon-MM bank of CHANNELS down-counter timers with maskable irq
module avalon_timer_bank
    import avalon_timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic          clk,
    input  logic          resetN,
    avalon_timer_bank_if.slave bus
);

    localparam int ADDR_W = $clog2(CHANNELS) + 2;

    logic [ADDR_W-1:0] addr;
    logic [31:0]       ch_sel;
    logic [1:0]        reg_off;

    assign addr    = bus.address;
    assign ch_sel  = 32'(addr) >> 2;
    assign reg_off = addr[1:0];

    logic [WIDTH-1:0]    count_a  [CHANNELS];
    logic [WIDTH-1:0]    reload_a [CHANNELS];
    ctrl_t               ctrl_a   [CHANNELS];
    logic [1:0]          status_a [CHANNELS];
    logic [CHANNELS-1:0] irq_req;
    logic [31:0]         rd_word;

    // Out-of-range channel indices never match a channel, so those writes vanish.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit = bus.write && (ch_sel == 32'(g));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .resetN    (resetN),
            .we_count  (hit && (reg_off == REG_COUNT)),
            .we_reload (hit && (reg_off == REG_RELOAD)),
            .we_ctrl   (hit && (reg_off == REG_CTRL)),
            .w1c       ({2{hit && (reg_off == REG_STATUS)}} & bus.dataIn[1:0]),
            .dataIn    (bus.dataIn),
            .count     (count_a[g]),
            .reload    (reload_a[g]),
            .ctrl      (ctrl_a[g]),
            .status    (status_a[g]),
            .irqReq    (irq_req[g])
        );
    end

    // Read mux over current register state; unmatched channels read zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == 32'(i)) begin
                case (reg_off)
                    REG_COUNT:  rd_word = 32'(count_a[i]);
                    REG_RELOAD: rd_word = 32'(reload_a[i]);
                    REG_CTRL:   rd_word = 32'(ctrl_a[i]);
                    REG_STATUS: rd_word = 32'(status_a[i]);
                    default:    rd_word = '0;
                endcase
            end
        end
    end

    // One-cycle registered read path; dataOut holds between reads.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.readValid <= 1'b0;
            bus.dataOut   <= '0;
        end else begin
            bus.readValid <= bus.read;
            if (bus.read) begin
                bus.dataOut <= rd_word;
            end
        end
    end

    assign bus.irq = |irq_req;

endmodule
